execute_pipe: RTL and testbench
===============================

EXECUTE_PIPE -- requirements
Module: execute_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 64, datapath width; legal values 16..64.
REQ-002 SHALL have clk_i  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have rst_i  input  1  reset; synchronous, active-high.
REQ-004 SHALL have in_valid_i  input  1 and in_ready_o  output  1: upstream handshake.
REQ-005 SHALL have icode_i, ifun_i  input  4 each; valA_i, valB_i, valC_i  input  WIDTH, signed; dstE_i  input  4.
REQ-006 SHALL have m_stat_bad_i  input  1: an exception is in progress downstream, so CC updates are suppressed.
REQ-007 SHALL have out_valid_o  output  1 and out_ready_i  input  1: downstream handshake.
REQ-008 SHALL have icode_o  output  4; valE_o, valA_o  output  WIDTH; dstE_o  output  4; Cnd_o  output  1; cc_o  output  3 {zf,sf,of}.

Function
REQ-009 SHALL accept an instruction when in_valid_i && in_ready_o, and register the results as the output slot; latency is 1 cycle for all non-multiply operations.
REQ-010 SHALL drive in_ready_o = (~out_valid_o | out_ready_i) & ~busy, where busy is the multiply state; this gives full throughput when downstream is ready.
REQ-011 SHALL hold the output slot unchanged while out_valid_o && ~out_ready_i; out_valid_o clears on a drain cycle with no new accept.
REQ-012 SHALL select aluA as: valA_i for CMOVQ/OPQ; valC_i for IRMOVQ/RMMOVQ/MRMOVQ; -8 for CALL/PUSHQ; +8 for RET/POPQ; 0 otherwise. Constants SHALL be sign-extended to WIDTH.
REQ-013 SHALL select aluB as: 0 for CMOVQ/IRMOVQ; valB_i for RMMOVQ/MRMOVQ/OPQ/CALL/RET/PUSHQ/POPQ; 0 otherwise.
REQ-014 SHALL compute valE = aluB op aluA, modulo 2^WIDTH. op is ifun_i for OPQ (0 add, 1 sub, 2 and, 3 xor; other codes are treated as add) and add for all other icodes.
REQ-015 SHALL update cc only on accept of an OPQ when m_stat_bad_i=0: zf=(valE==0); sf=valE[WIDTH-1].
REQ-016 SHALL set of on add = (aluA[MSB]==aluB[MSB]) & (valE[MSB]!=aluA[MSB]); on sub = (aluA[MSB]!=aluB[MSB]) & (valE[MSB]!=aluB[MSB]); on and/xor, of=0.
REQ-017 SHALL evaluate Cnd for CMOVQ/JXX from the cc register value before this instruction's edge, using ifun codes 0 yes, 1 le, 2 l, 3 e, 4 ne, 5 ge, 6 g. Codes 7..15 give Cnd=0. For other icodes, Cnd=0.
REQ-018 SHALL output dstE_o = 0xF when the instruction is CMOVQ and Cnd=0; otherwise dstE_o = dstE_i. valA_o and icode_o SHALL be registered copies of their inputs.
REQ-019 SHALL make an OPQ followed back-to-back by a CMOVQ/JXX see the OPQ's cc result.
REQ-020 SHALL drive cc_o continuously from the cc register.

Reset
REQ-021 SHALL, while rst_i=1 at an edge, set out_valid_o=0, valE_o=0, valA_o=0, icode_o=0, dstE_o=0xF, Cnd_o=0, cc=3'b100, and the multiply FSM to IDLE.
REQ-022 SHALL hold in_ready_o=0 during reset; assertion mid-operation (including mid-multiply) SHALL discard in-flight work without a partial output.

Configuration
REQ-023 SHALL, with EXECUTE_PIPE_MUL_EN defined, implement OPQ ifun 4 as an unsigned shift-add multiply. FSM states: IDLE -> MUL (WIDTH cycles, one multiplier bit per cycle, busy=1) -> IDLE, with the low WIDTH product bits written to the output slot.
REQ-024 SHALL, for a multiply, set zf/sf from the product and of=0; cc updates at completion, gated by m_stat_bad_i sampled on that cycle.
REQ-025 SHALL, without EXECUTE_PIPE_MUL_EN, treat ifun 4 as add with no multiply FSM logic present.

Verification
REQ-026 SHALL check: OPQ sub with valA=1, valB=1 -> next cycle valE_o=0, cc_o=3'b100; then JXX ifun 3 -> Cnd_o=1.
REQ-027 SHALL check: WIDTH=64 OPQ add with valA=valB=0x4000_0000_0000_0000 -> valE_o=0x8000_0000_0000_0000, cc_o=3'b011.
REQ-028 SHALL check: out_ready_i=0 for 3 cycles with in_valid_i=1 -> in_ready_o=0 and outputs stable; on release, consecutive instructions are accepted every cycle.
REQ-029 SHALL check: OPQ xor with m_stat_bad_i=1 -> cc_o is unchanged; CMOVQ ifun 4 with zf=1 -> dstE_o=0xF.
REQ-030 SHALL check, with EXECUTE_PIPE_MUL_EN and WIDTH=16: 7*9 -> in_ready_o low for 16 cycles, then valE_o=63; rst_i asserted at cycle 5 of the multiply -> out_valid_o=0 and cc_o=3'b100.

Source files
------------

// File: rtl/execute_pipe.sv
// execute_pipe: execute stage with ALU, condition codes and a one-deep output slot behind a valid/ready handshake.
// Define EXECUTE_PIPE_MUL_EN to add a serial shift-add multiplier for OPQ ifun 4 (otherwise ifun 4 is an add).
module execute_pipe #(
    parameter int WIDTH = 64
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    in_valid_i,
    output logic                    in_ready_o,
    input  logic [3:0]              icode_i,
    input  logic [3:0]              ifun_i,
    input  logic signed [WIDTH-1:0] valA_i,
    input  logic signed [WIDTH-1:0] valB_i,
    input  logic signed [WIDTH-1:0] valC_i,
    input  logic [3:0]              dstE_i,
    input  logic                    m_stat_bad_i,
    output logic                    out_valid_o,
    input  logic                    out_ready_i,
    output logic [3:0]              icode_o,
    output logic [WIDTH-1:0]        valE_o,
    output logic [WIDTH-1:0]        valA_o,
    output logic [3:0]              dstE_o,
    output logic                    Cnd_o,
    output logic [2:0]              cc_o
);

    localparam logic [3:0] I_CMOVQ  = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;
    localparam logic [3:0] R_NONE   = 4'hF;

    localparam logic [WIDTH-1:0] POS8 = WIDTH'(8);
    localparam logic [WIDTH-1:0] NEG8 = ~WIDTH'(7);

    typedef enum logic [1:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_XOR} alu_op_e;

    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [WIDTH-1:0] val_e;
    alu_op_e          alu_op;
    logic             of_flag;
    logic             is_opq;
    logic             is_cond;
    logic             cnd_raw;
    logic             cnd;
    logic             accept;
    logic             busy;
    logic [2:0]       cc_q;
    logic             zf, sf, of;

    assign is_opq  = (icode_i == I_OPQ);
    assign is_cond = (icode_i == I_CMOVQ) || (icode_i == I_JXX);
    assign {zf, sf, of} = cc_q;
    assign cc_o    = cc_q;

    assign in_ready_o = (~out_valid_o | out_ready_i) & ~busy & ~rst_i;
    assign accept     = in_valid_i & in_ready_o;

    // NOTE: every always_comb output gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        alu_a = '0;
        alu_b = '0;
        case (icode_i)
            I_CMOVQ:            alu_a = valA_i;
            I_OPQ: begin
                alu_a = valA_i;
                alu_b = valB_i;
            end
            I_IRMOVQ:           alu_a = valC_i;
            I_RMMOVQ, I_MRMOVQ: begin
                alu_a = valC_i;
                alu_b = valB_i;
            end
            I_CALL, I_PUSHQ: begin
                alu_a = NEG8;
                alu_b = valB_i;
            end
            I_RET, I_POPQ: begin
                alu_a = POS8;
                alu_b = valB_i;
            end
            default: ;
        endcase
    end

    always_comb begin
        alu_op = ALU_ADD;
        if (is_opq) begin
            case (ifun_i)
                4'd1:    alu_op = ALU_SUB;
                4'd2:    alu_op = ALU_AND;
                4'd3:    alu_op = ALU_XOR;
                default: alu_op = ALU_ADD;
            endcase
        end
    end

    // valE = aluB op aluA; overflow judged on operand and result sign bits.
    always_comb begin
        val_e   = alu_b + alu_a;
        of_flag = (alu_a[WIDTH-1] == alu_b[WIDTH-1]) && (val_e[WIDTH-1] != alu_a[WIDTH-1]);
        case (alu_op)
            ALU_SUB: begin
                val_e   = alu_b - alu_a;
                of_flag = (alu_a[WIDTH-1] != alu_b[WIDTH-1]) && (val_e[WIDTH-1] != alu_b[WIDTH-1]);
            end
            ALU_AND: begin
                val_e   = alu_b & alu_a;
                of_flag = 1'b0;
            end
            ALU_XOR: begin
                val_e   = alu_b ^ alu_a;
                of_flag = 1'b0;
            end
            default: ;
        endcase
    end

    always_comb begin
        cnd_raw = 1'b0;
        case (ifun_i)
            4'd0:    cnd_raw = 1'b1;
            4'd1:    cnd_raw = (sf ^ of) | zf;
            4'd2:    cnd_raw = sf ^ of;
            4'd3:    cnd_raw = zf;
            4'd4:    cnd_raw = ~zf;
            4'd5:    cnd_raw = ~(sf ^ of);
            4'd6:    cnd_raw = ~(sf ^ of) & ~zf;
            default: cnd_raw = 1'b0;
        endcase
    end

    assign cnd = is_cond & cnd_raw;

`ifdef EXECUTE_PIPE_MUL_EN
    localparam int CW = $clog2(WIDTH);

    typedef enum logic {S_IDLE, S_MUL} mul_state_e;

    mul_state_e       state_q;
    logic [WIDTH-1:0] mul_acc_q;
    logic [WIDTH-1:0] mul_mcand_q;
    logic [WIDTH-1:0] mul_mplier_q;
    logic [WIDTH-1:0] mul_sum;
    logic [CW-1:0]    mul_cnt_q;
    logic             is_mul;
    logic             mul_done;

    assign is_mul   = is_opq && (ifun_i == 4'd4);
    assign busy     = (state_q == S_MUL);
    assign mul_sum  = mul_acc_q + (mul_mplier_q[0] ? mul_mcand_q : '0);
    assign mul_done = busy && (mul_cnt_q == CW'(WIDTH - 1));

    // NOTE: datapath-only registers skip reset; the FSM state alone decides whether they are live.
    always_ff @(posedge clk_i) begin
        if (accept && is_mul) begin
            mul_acc_q    <= '0;
            mul_mcand_q  <= alu_b;
            mul_mplier_q <= alu_a;
            mul_cnt_q    <= '0;
        end else if (busy) begin
            mul_acc_q    <= mul_sum;
            mul_mcand_q  <= mul_mcand_q << 1;
            mul_mplier_q <= mul_mplier_q >> 1;
            mul_cnt_q    <= mul_cnt_q + CW'(1);
        end
    end
`else
    assign busy = 1'b0;
`endif

    // NOTE: non-blocking assignments so every register updates from pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            out_valid_o <= 1'b0;
            valE_o      <= '0;
            valA_o      <= '0;
            icode_o     <= '0;
            dstE_o      <= R_NONE;
            Cnd_o       <= 1'b0;
            cc_q        <= 3'b100;
`ifdef EXECUTE_PIPE_MUL_EN
            state_q     <= S_IDLE;
`endif
        end else begin
`ifdef EXECUTE_PIPE_MUL_EN
            if (mul_done) begin
                state_q     <= S_IDLE;
                out_valid_o <= 1'b1;
                valE_o      <= mul_sum;
                if (!m_stat_bad_i)
                    cc_q <= {mul_sum == '0, mul_sum[WIDTH-1], 1'b0};
            end else if (accept && is_mul) begin
                state_q     <= S_MUL;
                out_valid_o <= 1'b0;
                icode_o     <= icode_i;
                valA_o      <= valA_i;
                dstE_o      <= dstE_i;
                Cnd_o       <= 1'b0;
            end else
`endif
            if (accept) begin
                out_valid_o <= 1'b1;
                icode_o     <= icode_i;
                valE_o      <= val_e;
                valA_o      <= valA_i;
                dstE_o      <= ((icode_i == I_CMOVQ) && !cnd) ? R_NONE : dstE_i;
                Cnd_o       <= cnd;
                if (is_opq && !m_stat_bad_i)
                    cc_q <= {val_e == '0, val_e[WIDTH-1], of_flag};
            end else if (out_ready_i) begin
                out_valid_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_execute_pipe.sv
// tb_execute_pipe: directed literal checks plus random traffic compared every cycle against a transaction-level model.
module tb_execute_pipe;
`ifdef EXECUTE_PIPE_MUL_EN
    localparam int W      = 16;
    localparam bit MUL_EN = 1'b1;
`else
    localparam int W      = 64;
    localparam bit MUL_EN = 1'b0;
`endif

    logic                clk_i = 1'b0;
    logic                rst_i;
    logic                in_valid_i;
    logic                in_ready_o;
    logic [3:0]          icode_i;
    logic [3:0]          ifun_i;
    logic signed [W-1:0] valA_i;
    logic signed [W-1:0] valB_i;
    logic signed [W-1:0] valC_i;
    logic [3:0]          dstE_i;
    logic                m_stat_bad_i;
    logic                out_valid_o;
    logic                out_ready_i;
    logic [3:0]          icode_o;
    logic [W-1:0]        valE_o;
    logic [W-1:0]        valA_o;
    logic [3:0]          dstE_o;
    logic                Cnd_o;
    logic [2:0]          cc_o;

    int checks = 0;
    int errors = 0;

    execute_pipe #(.WIDTH(W)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .icode_i(icode_i), .ifun_i(ifun_i),
        .valA_i(valA_i), .valB_i(valB_i), .valC_i(valC_i), .dstE_i(dstE_i),
        .m_stat_bad_i(m_stat_bad_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .icode_o(icode_o), .valE_o(valE_o), .valA_o(valA_o), .dstE_o(dstE_o),
        .Cnd_o(Cnd_o), .cc_o(cc_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference semantics of one non-multiply instruction, straight from the instruction-set rules.
    function automatic void ref_exec(input logic [3:0] ic, input logic [3:0] fn,
                                     input logic [W-1:0] va, input logic [W-1:0] vb, input logic [W-1:0] vc,
                                     input logic [2:0] cc_in,
                                     output logic [W-1:0] e, output logic cnd, output logic [2:0] cc_new);
        logic [W-1:0]    a;
        logic [W-1:0]    b;
        logic signed [W:0] exact;
        bit              arith;
        bit              czf, csf, cof, lt;
        a = '0;
        b = '0;
        case (ic)
            4'h2:       a = va;
            4'h3:       a = vc;
            4'h4, 4'h5: begin a = vc; b = vb; end
            4'h6:       begin a = va; b = vb; end
            4'h8, 4'hA: begin a = '0 - W'(8); b = vb; end
            4'h9, 4'hB: begin a = W'(8); b = vb; end
            default: ;
        endcase
        e     = b + a;
        exact = $signed({b[W-1], b}) + $signed({a[W-1], a});
        arith = 1'b1;
        if (ic == 4'h6) begin
            if (fn == 4'd1) begin
                e     = b - a;
                exact = $signed({b[W-1], b}) - $signed({a[W-1], a});
            end else if (fn == 4'd2) begin
                e     = b & a;
                arith = 1'b0;
            end else if (fn == 4'd3) begin
                e     = b ^ a;
                arith = 1'b0;
            end
        end
        // Overflow: the true signed result does not fit back into W bits.
        cc_new = {e == '0, e[W-1], arith && (exact != $signed({e[W-1], e}))};
        {czf, csf, cof} = cc_in;
        lt = csf ^ cof;
        case (fn)
            4'd0:    cnd = 1'b1;
            4'd1:    cnd = lt || czf;
            4'd2:    cnd = lt;
            4'd3:    cnd = czf;
            4'd4:    cnd = !czf;
            4'd5:    cnd = !lt;
            4'd6:    cnd = !lt && !czf;
            default: cnd = 1'b0;
        endcase
        if (!(ic == 4'h2 || ic == 4'h7))
            cnd = 1'b0;
    endfunction

    // Model state: output slot, cc and the remaining multiply cycles.
    bit           model_ok = 1'b0;
    bit           m_valid;
    logic [3:0]   m_icode;
    logic [3:0]   m_dst;
    logic [W-1:0] m_vale;
    logic [W-1:0] m_vala;
    logic         m_cnd;
    logic [2:0]   m_cc;
    int           m_mul_left;
    logic [W-1:0] m_prod;
    logic [W-1:0] mp_vala;
    logic [3:0]   mp_dst;

    always @(negedge clk_i) begin
        bit           ready_m;
        logic [W-1:0] e, ua, ub;
        logic         cnd;
        logic [2:0]   ccn;
        ready_m = !rst_i && (!m_valid || out_ready_i) && (m_mul_left == 0);
        if (model_ok) begin
            check("in_ready", 64'(in_ready_o), 64'(ready_m));
            check("out_valid", 64'(out_valid_o), 64'(m_valid));
            check("cc", 64'(cc_o), 64'(m_cc));
            if (m_valid) begin
                check("icode", 64'(icode_o), 64'(m_icode));
                check("valE", 64'(valE_o), 64'(m_vale));
                check("valA", 64'(valA_o), 64'(m_vala));
                check("dstE", 64'(dstE_o), 64'(m_dst));
                check("Cnd", 64'(Cnd_o), 64'(m_cnd));
            end
        end
        if (rst_i) begin
            model_ok   = 1'b1;
            m_valid    = 1'b0;
            m_cc       = 3'b100;
            m_mul_left = 0;
        end else if (model_ok) begin
            if (m_mul_left > 0) begin
                m_mul_left--;
                if (m_mul_left == 0) begin
                    m_valid = 1'b1;
                    m_icode = 4'h6;
                    m_vale  = m_prod;
                    m_vala  = mp_vala;
                    m_dst   = mp_dst;
                    m_cnd   = 1'b0;
                    if (!m_stat_bad_i)
                        m_cc = {m_prod == '0, m_prod[W-1], 1'b0};
                end
            end else if (in_valid_i && ready_m) begin
                if (MUL_EN && icode_i == 4'h6 && ifun_i == 4'd4) begin
                    ua         = valA_i;
                    ub         = valB_i;
                    m_prod     = ua * ub;
                    mp_vala    = valA_i;
                    mp_dst     = dstE_i;
                    m_mul_left = W;
                    m_valid    = 1'b0;
                end else begin
                    ref_exec(icode_i, ifun_i, valA_i, valB_i, valC_i, m_cc, e, cnd, ccn);
                    m_valid = 1'b1;
                    m_icode = icode_i;
                    m_vale  = e;
                    m_vala  = valA_i;
                    m_cnd   = cnd;
                    m_dst   = (icode_i == 4'h2 && !cnd) ? 4'hF : dstE_i;
                    if (icode_i == 4'h6 && !m_stat_bad_i)
                        m_cc = ccn;
                end
            end else if (out_ready_i) begin
                m_valid = 1'b0;
            end
        end
    end

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic send(input logic [3:0] ic, input logic [3:0] fn, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] c, input logic [3:0] d);
        in_valid_i = 1'b1;
        icode_i    = ic;
        ifun_i     = fn;
        valA_i     = a;
        valB_i     = b;
        valC_i     = c;
        dstE_i     = d;
    endtask

    function automatic logic [W-1:0] rand_val();
        logic [63:0] r;
        r = {$urandom, $urandom};
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return '1;
            2:       return {1'b1, {(W-1){1'b0}}};
            3:       return {1'b0, {(W-1){1'b1}}};
            4:       return W'($urandom_range(0, 16));
            default: return W'(r);
        endcase
    endfunction

    initial begin
        rst_i        = 1'b1;
        in_valid_i   = 1'b0;
        out_ready_i  = 1'b1;
        m_stat_bad_i = 1'b0;
        send(4'h0, 4'h0, '0, '0, '0, 4'h0);
        in_valid_i   = 1'b0;
        repeat (3) step();

        check("rst_in_ready", 64'(in_ready_o), 64'd0);
        check("rst_out_valid", 64'(out_valid_o), 64'd0);
        check("rst_valE", 64'(valE_o), 64'd0);
        check("rst_valA", 64'(valA_o), 64'd0);
        check("rst_icode", 64'(icode_o), 64'd0);
        check("rst_dstE", 64'(dstE_o), 64'hF);
        check("rst_Cnd", 64'(Cnd_o), 64'd0);
        check("rst_cc", 64'(cc_o), 64'b100);
        rst_i = 1'b0;

        // sub 1-1 gives zero, then je sees it
        send(4'h6, 4'd1, W'(1), W'(1), '0, 4'h3);
        step();
        check("sub_valE", 64'(valE_o), 64'd0);
        check("sub_cc", 64'(cc_o), 64'b100);
        send(4'h7, 4'd3, '0, '0, '0, 4'hF);
        step();
        check("je_Cnd", 64'(Cnd_o), 64'd1);

`ifndef EXECUTE_PIPE_MUL_EN
        send(4'h6, 4'd0, W'(64'h4000_0000_0000_0000), W'(64'h4000_0000_0000_0000), '0, 4'h2);
        step();
        check("add_ovf_valE", 64'(valE_o), 64'h8000_0000_0000_0000);
        check("add_ovf_cc", 64'(cc_o), 64'b011);
`endif

        // backpressure: slot held for 3 cycles, then one accept per cycle
        send(4'h3, 4'd0, '0, '0, W'(16'h11), 4'h1);
        step();
        out_ready_i = 1'b0;
        send(4'h3, 4'd0, '0, '0, W'(16'h22), 4'h2);
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_ready", 64'(in_ready_o), 64'd0);
            check("stall_valid", 64'(out_valid_o), 64'd1);
            check("stall_valE", 64'(valE_o), 64'h11);
        end
        out_ready_i = 1'b1;
        step();
        check("rel_valE0", 64'(valE_o), 64'h22);
        send(4'h3, 4'd0, '0, '0, W'(16'h33), 4'h3);
        step();
        check("rel_valE1", 64'(valE_o), 64'h33);
        check("rel_ready", 64'(in_ready_o), 64'd1);
        send(4'h3, 4'd0, '0, '0, W'(16'h44), 4'h4);
        step();
        check("rel_valE2", 64'(valE_o), 64'h44);

        // suppressed cc update, then cmovne with zf=1 is squashed
        send(4'h6, 4'd1, W'(5), W'(5), '0, 4'h1);
        step();
        m_stat_bad_i = 1'b1;
        send(4'h6, 4'd3, W'(1), W'(2), '0, 4'h1);
        step();
        m_stat_bad_i = 1'b0;
        check("bad_cc", 64'(cc_o), 64'b100);
        check("bad_valE", 64'(valE_o), 64'h3);
        send(4'h2, 4'd4, W'(16'h77), '0, '0, 4'h3);
        step();
        check("cmov_dstE", 64'(dstE_o), 64'hF);
        check("cmov_Cnd", 64'(Cnd_o), 64'd0);
        check("cmov_valE", 64'(valE_o), 64'h77);

`ifdef EXECUTE_PIPE_MUL_EN
        send(4'h6, 4'd4, W'(7), W'(9), '0, 4'h5);
        step();
        in_valid_i = 1'b0;
        for (int i = 0; i < 16; i++) begin
            check("mul_busy", 64'(in_ready_o), 64'd0);
            step();
        end
        check("mul_valid", 64'(out_valid_o), 64'd1);
        check("mul_valE", 64'(valE_o), 64'd63);
        check("mul_cc", 64'(cc_o), 64'b000);
        check("mul_ready", 64'(in_ready_o), 64'd1);
        send(4'h6, 4'd4, W'(3), W'(3), '0, 4'h5);
        step();
        in_valid_i = 1'b0;
        repeat (4) step();
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        check("mulrst_valid", 64'(out_valid_o), 64'd0);
        check("mulrst_cc", 64'(cc_o), 64'b100);
        repeat (20) step();
        check("mulrst_quiet", 64'(out_valid_o), 64'd0);
`endif

        for (int cyc = 0; cyc < 3000; cyc++) begin
            rst_i        = ($urandom_range(0, 299) == 0);
            in_valid_i   = ($urandom_range(0, 9) < 8);
            out_ready_i  = ($urandom_range(0, 3) != 0);
            m_stat_bad_i = ($urandom_range(0, 9) == 0);
            case ($urandom_range(0, 5))
                0:       icode_i = 4'h6;
                1:       icode_i = 4'h2;
                2:       icode_i = 4'h7;
                default: icode_i = 4'($urandom_range(0, 15));
            endcase
            ifun_i = ($urandom_range(0, 3) != 0) ? 4'($urandom_range(0, 6)) : 4'($urandom_range(0, 15));
            valA_i = rand_val();
            valB_i = rand_val();
            valC_i = rand_val();
            dstE_i = 4'($urandom_range(0, 15));
            step();
        end

        rst_i       = 1'b0;
        in_valid_i  = 1'b0;
        out_ready_i = 1'b1;
        repeat (W + 4) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
